// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Owns the single data-memory port. Arbitrates between the
//               committed-store path (ROB head) and the speculative load
//               path (memory reservation station), keeps one request
//               outstanding, and routes the response back to its requester.
//               Load responses made stale by a pipeline flush are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ROB_IDX_W    = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 ld_req_valid,
    input  logic [31:0]          ld_req_addr,
    input  logic [3:0]           ld_req_rmask,
    input  logic [ROB_IDX_W-1:0] ld_req_tag,
    output logic                 ld_req_ready,
    output logic                 ld_resp_valid,
    output logic [31:0]          ld_resp_rdata,
    output logic [ROB_IDX_W-1:0] ld_resp_tag,

    input  logic                 st_req_valid,
    input  logic [31:0]          st_req_addr,
    input  logic [3:0]           st_req_wmask,
    input  logic [31:0]          st_req_wdata,
    output logic                 st_req_ready,
    output logic                 st_done,

    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_resp,

    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOAD_WAIT    = 2'd1,
        STORE_WAIT   = 2'd2,
        LOAD_DISCARD = 2'd3
    } state_e;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [3:0]             rmask_q, rmask_d;
    logic [3:0]             wmask_q, wmask_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [ROB_IDX_W-1:0]   tag_q, tag_d;
    logic [3:0]             streak_q, streak_d;

    logic                   w_idle;
    logic                   w_ld_priority;
    logic                   w_ld_grant;
    logic                   w_st_grant;
    logic                   w_unused_addr_lsbs;

    // Loads address whole words; the byte offset is carried by the mask.
    assign w_unused_addr_lsbs = ^ld_req_addr[1:0];

    // Arbitration: stores win ties until the waiting load has been passed
    // over STARVE_LIMIT times in a row. A load never enters during a flush.
    assign w_idle        = (state_q == IDLE);
    assign w_ld_priority = (streak_q == c_STARVE_LIMIT);
    assign ld_req_ready  = w_idle && !flush && !(st_req_valid && !w_ld_priority);
    assign st_req_ready  = w_idle && !(ld_req_valid && !flush && w_ld_priority);
    assign w_ld_grant    = ld_req_valid && ld_req_ready;
    assign w_st_grant    = st_req_valid && st_req_ready;

    assign dmem_addr     = addr_q;
    assign dmem_rmask    = rmask_q;
    assign dmem_wmask    = wmask_q;
    assign dmem_wdata    = wdata_q;
    assign ld_resp_rdata = dmem_rdata;
    assign ld_resp_tag   = tag_q;
    assign busy          = !w_idle;

    // Next-state, request capture, response routing and starvation tracking.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rmask_d       = rmask_q;
        wmask_d       = wmask_q;
        wdata_d       = wdata_q;
        tag_d         = tag_q;
        streak_d      = streak_q;
        ld_resp_valid = 1'b0;
        st_done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_ld_grant) begin
                    addr_d   = {ld_req_addr[31:2], 2'b00};
                    rmask_d  = ld_req_rmask;
                    wmask_d  = 4'b0000;
                    tag_d    = ld_req_tag;
                    streak_d = 4'd0;
                    state_d  = LOAD_WAIT;
                end else if (w_st_grant) begin
                    addr_d  = st_req_addr;
                    rmask_d = 4'b0000;
                    wmask_d = st_req_wmask;
                    wdata_d = st_req_wdata;
                    state_d = STORE_WAIT;
                    if (ld_req_valid && !w_ld_priority) begin
                        streak_d = streak_q + 4'd1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_resp) begin
                    // A flush in the response cycle kills the result too.
                    ld_resp_valid = !flush;
                    rmask_d       = 4'b0000;
                    wmask_d       = 4'b0000;
                    state_d       = IDLE;
                end else if (flush) begin
                    state_d = LOAD_DISCARD;
                end
            end
            LOAD_DISCARD: begin
                // Memory cannot abort; keep the request up and swallow the reply.
                if (dmem_resp) begin
                    rmask_d = 4'b0000;
                    wmask_d = 4'b0000;
                    state_d = IDLE;
                end
            end
            STORE_WAIT: begin
                // Committed stores are architectural, so flush has no effect here.
                if (dmem_resp) begin
                    st_done = 1'b1;
                    rmask_d = 4'b0000;
                    wmask_d = 4'b0000;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!ld_req_valid) begin
            streak_d = 4'd0;
        end
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            rmask_q  <= 4'd0;
            wmask_q  <= 4'd0;
            wdata_q  <= 32'd0;
            tag_q    <= '0;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rmask_q  <= rmask_d;
            wmask_q  <= wmask_d;
            wdata_q  <= wdata_d;
            tag_q    <= tag_d;
            streak_q <= streak_d;
        end
    end

endmodule
`default_nettype wire
